// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single add/sub controller with special-case fast path
module fp_add_sequencer #(
  parameter int ALIGN_STEP = 4,
  parameter int ALIGN_CAP = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        special,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CLASSIFY, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;
  logic [31:0] a, b, fast;
  logic [26:0] x, y, y_sh, y_al, m_add;
  logic [27:0] sum;
  logic [24:0] rnd;
  logic [23:0] sig_a, sig_b;
  logic [8:0] e, e_add, e_rnd;
  logic [7:0] ea, eb, dd;
  logic [4:0] d, k, d_cl;
  logic sx, sub, big, za, zb, ia, ib, na, nb, hit, bpick, up;
  // operand classification, fast-path result and the per-step datapath values
  always_comb begin
    za = a[30:0] == 31'h0;
    zb = b[30:0] == 31'h0;
    ia = a[30:23] == 8'hff && a[22:0] == 23'h0;
    ib = b[30:23] == 8'hff && b[22:0] == 23'h0;
    na = a[30:23] == 8'hff && a[22:0] != 23'h0;
    nb = b[30:23] == 8'hff && b[22:0] != 23'h0;
    hit = za | zb | ia | ib | na | nb;
    bpick = b[21:0] > a[21:0];
    fast = (na && nb) ? {bpick ? b[31] : a[31], 9'h1ff, bpick ? b[21:0] : a[21:0]} :
           (za && zb) ? {a[31] & b[31], 31'h0} :
           (za || nb) ? b | {9'h0, nb, 22'h0} :
           (zb || na) ? a | {9'h0, na, 22'h0} :
           ia ? (!ib ? a : (a[31] == b[31] ? b : 32'hff800001)) : b;
    sig_a = {a[30:23] != 8'h0, a[22:0]};
    sig_b = {b[30:23] != 8'h0, b[22:0]};
    ea = a[30:23] == 8'h0 ? 8'd1 : a[30:23];
    eb = b[30:23] == 8'h0 ? 8'd1 : b[30:23];
    big = a[30:0] >= b[30:0];
    dd = big ? ea - eb : eb - ea;
    d_cl = dd > 8'(ALIGN_CAP) ? 5'(ALIGN_CAP) : dd[4:0];
    k = d > 5'(ALIGN_STEP) ? 5'(ALIGN_STEP) : d;
    y_sh = y >> k;
    y_al = {y_sh[26:1], y_sh[0] | |(y & ((27'd1 << k) - 27'd1))};
    sum = sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    m_add = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];
    e_add = e + {8'h0, sum[27]};
    up = x[2] & (x[3] | x[1] | x[0]);
    rnd = {1'b0, x[26:3]} + {24'h0, up};
    e_rnd = rnd[24] ? e + 9'd1 : (rnd[23] ? e : 9'd0);
  end
  // control FSM sequencing capture, classify, align, add, normalize, round and result handoff
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= 32'h0;
      special <= 1'b0;
      busy <= 1'b0;
      a <= 32'h0;
      b <= 32'h0;
      x <= 27'h0;
      y <= 27'h0;
      e <= 9'h0;
      d <= 5'h0;
      sx <= 1'b0;
      sub <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          a <= op_a;
          b <= {op_b[31] ^ op_sub, op_b[30:0]};
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= CLASSIFY;
        end
        CLASSIFY: if (hit) begin
          result <= fast;
          special <= 1'b1;
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          x <= {big ? sig_a : sig_b, 3'b0};
          y <= {big ? sig_b : sig_a, 3'b0};
          e <= {1'b0, big ? ea : eb};
          d <= d_cl;
          sx <= big ? a[31] : b[31];
          sub <= a[31] ^ b[31];
          state <= d_cl != 5'h0 ? ALIGN : ADD;
        end
        ALIGN: begin
          y <= y_al;
          d <= d - k;
          if (d == k) state <= ADD;
        end
        ADD: if (sum == 28'h0 || e_add >= 9'd255) begin
          result <= sum == 28'h0 ? 32'h0 : {sx, 8'hff, 23'h0};
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          x <= m_add;
          e <= e_add;
          state <= (!m_add[26] && e_add > 9'd1) ? NORM : ROUND;
        end
        NORM: begin
          x <= x << 1;
          e <= e - 9'd1;
          state <= (!x[25] && e > 9'd2) ? NORM : ROUND;
        end
        ROUND: begin
          result <= e_rnd >= 9'd255 ? {sx, 8'hff, 23'h0} : {sx, e_rnd[7:0], rnd[22:0]};
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          special <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed-vector bench for the FP add/sub sequencer
module tb_fp_add_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [31:0] op_a = 32'h0, op_b = 32'h0;
  logic in_ready, out_valid, special, busy;
  logic [31:0] result;
  int tests = 0, fails = 0;

  fp_add_sequencer #(.ALIGN_STEP(4), .ALIGN_CAP(27)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .special(special), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold,
                     output logic [31:0] res, output logic sp, output int lat);
    logic ok;
    @(negedge clk);
    op_a = x; op_b = y; op_sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    @(negedge clk);
    res = result;
    sp = special;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op_a = 32'h3f800000; op_b = 32'h3f800000;
      @(negedge clk);
      ok &= out_valid && !in_ready && busy && result === res;
    end
    in_valid = 1'b0;
    if (hold > 0) check("hold_stable", {31'h0, ok}, 32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release", {28'h0, out_valid, in_ready, busy, special}, 32'h4);
  endtask

  initial begin
    logic [31:0] r;
    logic sp, ok;
    int lat;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_special", {31'h0, special}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;

    run(32'h3f800000, 32'h3f800000, 1'b0, 0, r, sp, lat);
    check("one_plus_one", r, 32'h40000000);
    check("one_plus_one_sp", {31'h0, sp}, 32'h0);
    check("one_plus_one_lat", lat, 32'd4);

    run(32'h3f800000, 32'h3f800000, 1'b1, 0, r, sp, lat);
    check("one_minus_one", r, 32'h00000000);
    check("one_minus_one_sp", {31'h0, sp}, 32'h0);

    run(32'h00000000, 32'h80000000, 1'b0, 0, r, sp, lat);
    check("zero_negzero", r, 32'h00000000);
    check("zero_negzero_sp", {31'h0, sp}, 32'h1);

    run(32'h7f800000, 32'hff800000, 1'b0, 0, r, sp, lat);
    check("inf_neginf", r, 32'hff800001);
    check("inf_neginf_sp", {31'h0, sp}, 32'h1);
    check("inf_neginf_lat", lat, 32'd2);

    run(32'h7fc00001, 32'h7f800005, 1'b0, 0, r, sp, lat);
    check("nan_pick", r, 32'h7fc00005);

    run(32'h3f800000, 32'h30800000, 1'b0, 0, r, sp, lat);
    check("clamp_align", r, 32'h3f800000);
    check("clamp_align_lat", lat, 32'd11);

    run(32'h3f800001, 32'h33800000, 1'b0, 0, r, sp, lat);
    check("tie_odd", r, 32'h3f800002);
    check("tie_odd_lat", lat, 32'd10);

    run(32'h00000001, 32'h00000001, 1'b0, 0, r, sp, lat);
    check("subnormal_sum", r, 32'h00000002);
    check("subnormal_lat", lat, 32'd4);

    run(32'h7f7fffff, 32'h7f7fffff, 1'b0, 0, r, sp, lat);
    check("overflow", r, 32'h7f800000);
    check("overflow_sp", {31'h0, sp}, 32'h0);

    run(32'h3f800000, 32'h3f7fffff, 1'b1, 0, r, sp, lat);
    check("cancel_norm", r, 32'h33800000);
    check("cancel_norm_lat", lat, 32'd29);

    run(32'h40000000, 32'h40400000, 1'b1, 0, r, sp, lat);
    check("neg_diff", r, 32'hbf800000);
    check("neg_diff_lat", lat, 32'd5);

    run(32'h40400000, 32'h3f800000, 1'b0, 10, r, sp, lat);
    check("hold_result", r, 32'h40800000);

    @(negedge clk);
    op_a = 32'h3f800000; op_b = 32'h30800000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", {29'h0, busy, in_ready, out_valid}, 32'h2);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ok &= !out_valid && in_ready && !busy;
    end
    check("abort_no_output", {31'h0, ok}, 32'h1);

    run(32'h3f800000, 32'h3f800000, 1'b0, 0, r, sp, lat);
    check("after_abort", r, 32'h40000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
